sync_filter_bank: RTL and testbench
===================================

// Module: sync_filter_bank
// PURPOSE
//  Parametrised successor to the fixed 2-flop synchroniser. Brings N independent
//  asynchronous level signals into the clk domain through a STAGES-deep flop chain.
//  A per-channel glitch filter follows the chain, plus registered rise/fall pulses.
//  Used for buttons, status lines and slow cross-domain flags.
//  Not for multi-bit buses; use Gray-coded pointers for those.
// PARAMETERS
//  N              16  number of independent channels (>=1)
//  STAGES          2  synchroniser flops per channel (>=2)
//  FILTER_CYCLES   4  consecutive differing synced samples required before out flips (>=1)
//  RST_VAL        '0  N-bit reset value of sync chain and out
// PORTS
//  clk         in   1  destination-domain clock; single clock, all state on posedge
//  rst         in   1  reset, asynchronous, active-high
//  in          in   N  asynchronous level inputs
//  out         out  N  synchronised, filtered levels
//  rise        out  N  one-cycle pulse: out[i] went 0->1 this cycle
//  fall        out  N  one-cycle pulse: out[i] went 1->0 this cycle
//  any_change  out  1  registered OR of (rise|fall) from the same edge; coincident with rise/fall
// BEHAVIOUR
//  Reset (async assert, any time incl. mid-filter):
//   - sync chain <= RST_VAL, out <= RST_VAL, counters <= 0
//   - rise, fall, any_change <= 0
//   - no pulse on reset release, even if in != RST_VAL
//   - a differing input is then filtered normally and pulses when accepted
//  Sync chain, per channel i:
//   - s[0] <= in[i], s[k] <= s[k-1]; synced value ys[i] = s[STAGES-1]
//   - no logic between chain flops; chain flops carry an ASYNC_REG/sync attribute
//  Filter, per channel, counter width $clog2(FILTER_CYCLES) (min 1 bit):
//   - ys == out: cnt <= 0 (any agreeing sample aborts a pending change)
//   - ys != out, cnt == FILTER_CYCLES-1: out <= ys, cnt <= 0
//   - ys != out otherwise: cnt <= cnt+1
//   - cnt never exceeds FILTER_CYCLES-1; no wrap
//  Pulses:
//   - rise[i] = 1 for exactly the cycle out[i] becomes 1 (same edge updates both)
//   - fall[i] is the same for 0
//   - rise[i] & fall[i] never both 1
//   - out[i] changes at most once per FILTER_CYCLES cycles
//  Latency:
//   - in changes before edge 1 and is held: ys changes at edge STAGES
//   - out, rise/fall and any_change update at edge STAGES+FILTER_CYCLES
//   - FILTER_CYCLES=1 gives pure sync+1 register: latency STAGES+1
//  Channels are fully independent; simultaneous changes on several channels
//  each pulse in their own cycle. any_change is 1 if any channel pulses.
//  Metastability: no channel-to-channel coherence guaranteed; a bit toggling near
//  the sampling edge may be resolved one cycle late.
// TESTING (N=4, STAGES=2, FILTER_CYCLES=4, RST_VAL=0 unless stated)
//  1 Reset: rst=1, in=4'hF -> out=0, rise=fall=0, any_change=0.
//    Release rst -> out=4'hF at 6th edge, with rise=4'hF and any_change=1 for one cycle.
//  2 Step: in[0] 0->1 held -> out[0]=1 and rise[0]=1 at edge 6 after the change.
//    rise[0]=0 at edge 7. No fall; channels 1-3 stay 0.
//  3 Glitch: in[1] high for 3 clk then low -> out[1], rise[1] and any_change never assert.
//    Repeat with 4 clk high -> rise[1] pulses, then fall[1] pulses 4 clk later.
//  4 Chatter: in[2] pattern 1,1,1,0,1,1,1,1 (one value per clk) -> counter restarts at
//    the 0. out[2] rises 4 synced-high samples after the last 0 reaches ys.
//  5 Reset mid-filter: in[3]=1 for 5 clk, assert rst for 1 clk -> out[3] stays 0, no pulse.
//    Held input then rises STAGES+4 edges after release.
//  6 Params: STAGES=3, FILTER_CYCLES=1, N=1 -> step latency exactly 4 edges.
//    1-clk input pulse (width >= 1 clk) propagates as a 1-clk out pulse with rise then fall.

Source files
------------

// File: rtl/sync_filter_bank.sv
// Multi-channel level synchroniser: STAGES-deep flop chain per channel, then a
// consecutive-sample glitch filter with registered rise/fall/any_change pulses.
module sync_filter_bank #(
  parameter int unsigned  N             = 16,
  parameter int unsigned  STAGES        = 2,
  parameter int unsigned  FILTER_CYCLES = 4,
  parameter logic [N-1:0] RST_VAL       = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         any_change
);

  localparam int unsigned   CW       = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [N-1:0] sync_q [STAGES];
  logic [N-1:0]  ys_c;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  out_d;
  logic [N-1:0]  rise_d;
  logic [N-1:0]  fall_d;

  // Pure flop chain; nothing may sit between these stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= in;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign ys_c = sync_q[STAGES-1];

  // Any agreeing sample clears the counter, so a change needs an unbroken run.
  always_comb begin
    out_d  = out;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N; i++) cnt_d[i] = '0;
    for (int i = 0; i < N; i++) begin
      if (ys_c[i] != out[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          out_d[i]  = ys_c[i];
          rise_d[i] = ys_c[i];
          fall_d[i] = ~ys_c[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out        <= RST_VAL;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      out        <= out_d;
      rise       <= rise_d;
      fall       <= fall_d;
      any_change <= |(rise_d | fall_d);
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank: default 4-channel configuration plus a
// STAGES=3 / FILTER_CYCLES=1 single-channel instance.
module tb_sync_filter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic [3:0] out, rise, fall;
  logic       any_change;
  logic [0:0] in6, out6, rise6, fall6;
  logic       any6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_filter_bank #(.N(4), .STAGES(2), .FILTER_CYCLES(4), .RST_VAL(4'h0)) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .rise(rise), .fall(fall),
    .any_change(any_change)
  );

  sync_filter_bank #(.N(1), .STAGES(3), .FILTER_CYCLES(1), .RST_VAL(1'b0)) dut6 (
    .clk(clk), .rst(rst), .in(in6), .out(out6), .rise(rise6), .fall(fall6),
    .any_change(any6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_main(input string tag, input logic [3:0] eo, input logic [3:0] er,
                            input logic [3:0] ef, input logic ea);
    check({tag, ".out"},  32'(out),        32'(eo));
    check({tag, ".rise"}, 32'(rise),       32'(er));
    check({tag, ".fall"}, 32'(fall),       32'(ef));
    check({tag, ".any"},  32'(any_change), 32'(ea));
  endtask

  initial begin
    rst = 1'b1;
    in  = 4'hF;
    in6 = 1'b0;

    // 1: reset holds outputs low; release filters the high input in at edge 6
    tick(); tick();
    check_main("reset", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_main($sformatf("rel_e%0d", i), (i >= 6) ? 4'hF : 4'h0,
                 (i == 6) ? 4'hF : 4'h0, 4'h0, i == 6);
    end

    rst = 1'b1; in = 4'h0;
    tick();
    rst = 1'b0;
    tick(); tick();
    check_main("idle", 4'h0, 4'h0, 4'h0, 1'b0);

    // 2: step on channel 0
    in = 4'h1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_main($sformatf("step_e%0d", i), (i >= 6) ? 4'h1 : 4'h0,
                 (i == 6) ? 4'h1 : 4'h0, 4'h0, i == 6);
    end

    // 3a: 3-cycle glitch on channel 1 is rejected
    in = 4'h3;
    tick(); tick(); tick();
    in = 4'h1;
    for (int i = 1; i <= 8; i++) begin
      check_main($sformatf("glitch3_%0d", i), 4'h1, 4'h0, 4'h0, 1'b0);
      tick();
    end

    // 3b: 4-cycle pulse on channel 1 passes: rise at edge 6, fall at edge 10
    in = 4'h3;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) in = 4'h1;
      check_main($sformatf("pulse4_e%0d", i), (i >= 6 && i < 10) ? 4'h3 : 4'h1,
                 (i == 6) ? 4'h2 : 4'h0, (i == 10) ? 4'h2 : 4'h0, i == 6 || i == 10);
    end

    // 4: chatter 1,1,1,0,1,1,1,1 on channel 2: the 0 restarts the count
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;  // bit j = value before edge j+1
      in = {1'b0, pat[0], 2'b01};
      for (int i = 1; i <= 12; i++) begin
        tick();
        in[2] = (i < 8) ? pat[i] : 1'b1;
        check_main($sformatf("chatter_e%0d", i), (i >= 10) ? 4'h5 : 4'h1,
                   (i == 10) ? 4'h4 : 4'h0, 4'h0, i == 10);
      end
    end

    // 5: reset mid-filter on channel 3; no pulse, then everything re-filters in
    in = 4'hD;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_main($sformatf("prerst_e%0d", i), 4'h5, 4'h0, 4'h0, 1'b0);
    end
    rst = 1'b1;
    #1;
    check_main("midrst_async", 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_main($sformatf("postrst_e%0d", i), (i >= 6) ? 4'hD : 4'h0,
                 (i == 6) ? 4'hD : 4'h0, 4'h0, i == 6);
    end

    // 6: STAGES=3, FILTER_CYCLES=1 -> latency 4 edges, 1-clk pulses survive
    in6 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("p6_step_out_e%0d", i),  32'(out6),  32'(i >= 4));
      check($sformatf("p6_step_rise_e%0d", i), 32'(rise6), 32'(i == 4));
    end
    in6 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("p6_fall_out_e%0d", i),  32'(out6),  32'(i < 4));
      check($sformatf("p6_fall_fall_e%0d", i), 32'(fall6), 32'(i == 4));
    end
    in6 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) in6 = 1'b0;
      check($sformatf("p6_pulse_out_e%0d", i),  32'(out6),  32'(i == 4));
      check($sformatf("p6_pulse_rise_e%0d", i), 32'(rise6), 32'(i == 4));
      check($sformatf("p6_pulse_fall_e%0d", i), 32'(fall6), 32'(i == 5));
      check($sformatf("p6_pulse_any_e%0d", i),  32'(any6),  32'(i == 4 || i == 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
